// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - raster-order image RAM reader presenting pixels on a ready/valid stream
module pixel_stream_tx #(
   parameter int I_F_BW = 8,
   parameter int IX     = 28,
   parameter int IY     = 28,
   parameter int ADDR_W = $clog2(IX*IY),
   localparam int RW    = $clog2(IY),
   localparam int CW    = $clog2(IX)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [I_F_BW-1:0] i_rd_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [I_F_BW-1:0] o_pixel,
   output logic [RW-1:0]     o_row,
   output logic [CW-1:0]     o_col,
   output logic              o_sof,
   output logic              o_eol,
   output logic              o_eof
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IX*IY-1);
   localparam logic [RW-1:0]     ROW_LAST  = RW'(IY-1);
   localparam logic [CW-1:0]     COL_LAST  = CW'(IX-1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2} state_t;

   typedef struct packed {
      logic [I_F_BW-1:0] pix;
      logic [RW-1:0]     row;
      logic [CW-1:0]     col;
      logic              sof;
      logic              eol;
      logic              eof;
   } entry_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_rd_all;
   logic                r_inflight;
   logic [RW-1:0]       r_wr_row;
   logic [CW-1:0]       r_wr_col;
   logic [1:0]          r_cnt;
   entry_t              r_q0;
   entry_t              r_q1;

   entry_t              w_arr;
   entry_t              w_head;
   entry_t              w_out;
   entry_t              w_e0;
   entry_t              w_e1;
   logic                w_valid;
   logic                w_pop;
   logic [1:0]          w_total;
   logic [1:0]          w_cnt_nxt;
   logic                w_rd_en;
   logic                w_col_last;
   logic                w_row_last;

   // The read returning this cycle is treated as the queue tail, so it can be
   // presented the same cycle it lands when nothing older is stored.
   assign w_col_last = (r_wr_col == COL_LAST);
   assign w_row_last = (r_wr_row == ROW_LAST);
   assign w_arr      = {i_rd_data, r_wr_row, r_wr_col,
                        (r_wr_row == '0) && (r_wr_col == '0),
                        w_col_last, w_row_last && w_col_last};
   assign w_head     = (r_cnt != 2'd0) ? r_q0 : w_arr;
   assign w_valid    = (r_cnt != 2'd0) || r_inflight;
   assign w_pop      = w_valid && i_ready;
   assign w_total    = r_cnt + {1'b0, r_inflight};
   assign w_cnt_nxt  = w_total - {1'b0, w_pop};
   assign w_rd_en    = (r_state == S_STREAM) && !r_rd_all && (w_cnt_nxt < 2'd2);
   assign w_e0       = (r_cnt != 2'd0) ? r_q0 : w_arr;
   assign w_e1       = (r_cnt == 2'd2) ? r_q1 : w_arr;
   assign w_out      = w_valid ? w_head : '0;

   assign o_rd_en    = w_rd_en;
   assign o_rd_addr  = r_rd_addr;
   assign o_valid    = w_valid;
   assign o_pixel    = w_out.pix;
   assign o_row      = w_out.row;
   assign o_col      = w_out.col;
   assign o_sof      = w_out.sof;
   assign o_eol      = w_out.eol;
   assign o_eof      = w_out.eof;

   // Frame state register.
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Frame sequencing: start request, end on acceptance of the last pixel, one-cycle done.
   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_IDLE:   if (i_start) w_state_nxt = S_STREAM;
         S_STREAM: begin
            o_busy = 1'b1;
            if (w_pop && w_head.eof) w_state_nxt = S_DONE;
         end
         S_DONE:   begin
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Read address generator; address parks on the last pixel once all reads are issued.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_addr  <= '0;
         r_rd_all   <= 1'b0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if (r_state != S_STREAM) begin
            r_rd_addr <= '0;
            r_rd_all  <= 1'b0;
         end else if (w_rd_en) begin
            if (r_rd_addr == ADDR_LAST) r_rd_all  <= 1'b1;
            else                        r_rd_addr <= r_rd_addr + 1'b1;
         end
      end
   end

   // Row/column of the next returning pixel, advanced as each read lands.
   always_ff @(posedge clk) begin
      if (!reset_n || r_state != S_STREAM) begin
         r_wr_row <= '0;
         r_wr_col <= '0;
      end else if (r_inflight) begin
         if (w_col_last) begin
            r_wr_col <= '0;
            if (!w_row_last) r_wr_row <= r_wr_row + 1'b1;
         end else begin
            r_wr_col <= r_wr_col + 1'b1;
         end
      end
   end

   // Two-entry pixel queue: drop the head on pop, append any returning pixel behind it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt <= 2'd0;
         r_q0  <= '0;
         r_q1  <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_q0  <= w_pop ? w_e1  : w_e0;
         r_q1  <= w_pop ? w_arr : w_e1;
      end
   end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - directed self-checking bench for pixel_stream_tx
module tb_pixel_stream_tx;

   localparam int IX   = 28;
   localparam int IY   = 28;
   localparam int NPIX = IX*IY;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_ready = 1'b1;
   logic       o_busy, o_done, o_rd_en, o_valid, o_sof, o_eol, o_eof;
   logic [9:0] o_rd_addr;
   logic [7:0] i_rd_data = 8'd0;
   logic [7:0] o_pixel;
   logic [4:0] o_row, o_col;
   logic [7:0] ram [0:NPIX-1];

   pixel_stream_tx dut (
      .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_valid(o_valid),
      .i_ready(i_ready), .o_pixel(o_pixel), .o_row(o_row), .o_col(o_col),
      .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof)
   );

   always #5 clk = ~clk;

   // Image RAM: one-cycle registered read.
   always @(posedge clk) if (o_rd_en) i_rd_data <= ram[o_rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   int pix_cnt, rd_cnt, seq_err, addr_err, occ_err, stall_err;
   int sof_cnt, eol_cnt, eof_cnt, eof_pix, first_rd_cyc, first_valid_cyc, done_cyc;
   int first_row, first_col, first_sof;
   int done_cnt = 0;
   bit stall_prev;
   logic [7:0] s_pix;
   logic [4:0] s_row, s_col;
   logic [2:0] s_flags;

   task automatic frame_begin();
      pix_cnt = 0; rd_cnt = 0; seq_err = 0; addr_err = 0; occ_err = 0; stall_err = 0;
      sof_cnt = 0; eol_cnt = 0; eof_cnt = 0; eof_pix = -1;
      first_rd_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
      first_row = -1; first_col = -1; first_sof = -1; stall_prev = 0;
   endtask

   // Consumer-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (stall_prev && (!o_valid || o_pixel != s_pix || o_row != s_row || o_col != s_col ||
                            {o_sof, o_eol, o_eof} != s_flags))
            stall_err++;
         if (o_rd_en) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (int'(o_rd_addr) != rd_cnt) addr_err++;
            if (rd_cnt - pix_cnt - ((o_valid && i_ready) ? 1 : 0) + 1 > 2) occ_err++;
            rd_cnt++;
         end
         if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (o_valid && i_ready) begin
            if (pix_cnt == 0) begin
               first_row = int'(o_row); first_col = int'(o_col); first_sof = int'(o_sof);
            end
            if (o_pixel != 8'(pix_cnt) || int'(o_row) != pix_cnt / IX ||
                int'(o_col) != pix_cnt % IX || o_sof != (pix_cnt == 0) ||
                o_eol != (pix_cnt % IX == IX-1) || o_eof != (pix_cnt == NPIX-1))
               seq_err++;
            sof_cnt += int'(o_sof);
            eol_cnt += int'(o_eol);
            if (o_eof) begin
               eof_cnt++;
               eof_pix = int'(o_pixel);
            end
            pix_cnt++;
         end
         stall_prev = o_valid && !i_ready;
         s_pix = o_pixel; s_row = o_row; s_col = o_col; s_flags = {o_sof, o_eol, o_eof};
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end else begin
         stall_prev = 0;
      end
   end

   task automatic start_frame(output int n);
      frame_begin();
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      n = cyc;
   endtask

   task automatic run_frame(input bit pattern, input bit repulse, input bit mid_reset);
      int  start_done = done_cnt;
      int  ph = 0;
      bit  pulsed = 0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         i_start = 1'b0;
         i_ready = pattern ? (ph % 4 == 0 || ph % 4 == 3) : 1'b1;
         ph++;
         if (repulse && !pulsed && pix_cnt == 100) begin
            i_start = 1'b1;
            pulsed  = 1;
         end
         if (mid_reset && pix_cnt >= 300) begin
            reset_n = 1'b0;
            return;
         end
         if (done_cnt != start_done) return;
      end
      check("frame_timeout", done_cnt - start_done, 1);
   endtask

   int n0, n1, d0, stale;

   initial begin
      for (int k = 0; k < NPIX; k++) ram[k] = 8'(k);
      frame_begin();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_rd_en", o_rd_en, 0);
      check("rst_rd_addr", o_rd_addr, 0);
      check("rst_valid", o_valid, 0);
      check("rst_pixel", o_pixel, 0);
      check("rst_row", o_row, 0);
      check("rst_col", o_col, 0);
      check("rst_sof", o_sof, 0);
      check("rst_eol", o_eol, 0);
      check("rst_eof", o_eof, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Full-rate frame: timing, order and flags
      start_frame(n0);
      check("a_busy", o_busy, 1);
      run_frame(0, 0, 0);
      check("a_first_rd_cyc", first_rd_cyc, n0);
      check("a_first_valid_cyc", first_valid_cyc, n0 + 1);
      check("a_done_cyc", done_cyc, n0 + NPIX + 1);
      check("a_pixels", pix_cnt, NPIX);
      check("a_reads", rd_cnt, NPIX);
      check("a_seq_err", seq_err, 0);
      check("a_addr_err", addr_err, 0);
      check("a_occ_err", occ_err, 0);
      check("a_sof_cnt", sof_cnt, 1);
      check("a_eol_cnt", eol_cnt, IY);
      check("a_eof_cnt", eof_cnt, 1);
      check("a_eof_pix", eof_pix, 15);

      // Back-to-back frame started in the idle cycle right after done
      check("idle_busy", o_busy, 0);
      check("idle_done", o_done, 0);
      check("idle_rd_addr", o_rd_addr, 0);
      start_frame(n1);
      run_frame(0, 0, 0);
      check("b_first_rd_cyc", first_rd_cyc, n1);
      check("b_first_valid_cyc", first_valid_cyc, n1 + 1);
      check("b_done_cyc", done_cyc, n1 + NPIX + 1);
      check("b_pixels", pix_cnt, NPIX);
      check("b_seq_err", seq_err, 0);
      check("b_addr_err", addr_err, 0);

      // Backpressure 1,0,0,1
      start_frame(n0);
      run_frame(1, 0, 0);
      i_ready = 1'b1;
      check("bp_pixels", pix_cnt, NPIX);
      check("bp_reads", rd_cnt, NPIX);
      check("bp_seq_err", seq_err, 0);
      check("bp_stall_err", stall_err, 0);
      check("bp_occ_err", occ_err, 0);
      check("bp_addr_err", addr_err, 0);

      // Start re-pulsed mid-frame is ignored
      d0 = done_cnt;
      start_frame(n0);
      run_frame(0, 1, 0);
      repeat (20) @(posedge clk);
      #1;
      check("rp_pixels", pix_cnt, NPIX);
      check("rp_done_cnt", done_cnt - d0, 1);
      check("rp_seq_err", seq_err, 0);
      check("rp_busy_after", o_busy, 0);

      // Reset mid-frame, then restart
      start_frame(n0);
      run_frame(0, 0, 1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("mr_valid", o_valid, 0);
      check("mr_busy", o_busy, 0);
      check("mr_rd_en", o_rd_en, 0);
      check("mr_seq_err", seq_err, 0);
      stale = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (o_valid || o_rd_en) stale++;
      end
      check("mr_no_stale", stale, 0);
      @(posedge clk); #1;
      start_frame(n0);
      run_frame(0, 0, 0);
      check("mr_first_row", first_row, 0);
      check("mr_first_col", first_col, 0);
      check("mr_first_sof", first_sof, 1);
      check("mr_pixels", pix_cnt, NPIX);
      check("mr_seq_err", seq_err, 0);
      check("mr_done_cyc", done_cyc, n0 + NPIX + 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 Parameter I_F_BW, default 8: pixel width in bits.
REQ-002 Parameter IX, default 28: image width in pixels (columns).
REQ-003 Parameter IY, default 28: image height in pixels (rows).
REQ-004 Parameter ADDR_W, default $clog2(IX*IY) (10): image RAM address width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 i_start  input  1  one-cycle request to stream one frame.
REQ-008 o_busy  output  1  high while a frame is in progress.
REQ-009 o_done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-010 o_rd_en  output  1  image RAM read strobe.
REQ-011 o_rd_addr  output  ADDR_W  image RAM read address, raster order (row*IX+col).
REQ-012 i_rd_data  input  I_F_BW  RAM data, valid exactly 1 cycle after o_rd_en.
REQ-013 o_valid  output  1  pixel present on o_pixel.
REQ-014 i_ready  input  1  consumer accepts pixel; transfer = o_valid && i_ready.
REQ-015 o_pixel  output  I_F_BW  pixel value.
REQ-016 o_row  output  $clog2(IY)  row index of o_pixel.
REQ-017 o_col  output  $clog2(IX)  column index of o_pixel.
REQ-018 o_sof / o_eol / o_eof  output  1 each  first pixel of frame / col==IX-1 / last pixel of frame; qualified by o_valid.

Function
REQ-019 FSM states SHALL be IDLE, STREAM, DONE; IDLE->STREAM on i_start, STREAM->DONE when pixel IX*IY-1 transfers, DONE->IDLE unconditionally after one cycle.
REQ-020 o_busy SHALL be 1 in STREAM, 0 in IDLE and DONE; o_done SHALL be 1 only in DONE.
REQ-021 i_start SHALL be ignored in STREAM and DONE; i_start in IDLE the cycle after DONE SHALL start a new frame.
REQ-022 Returned pixels SHALL be held in a 2-entry FIFO; o_valid = FIFO not empty; o_pixel/o_row/o_col/flags = FIFO head.
REQ-023 o_rd_en SHALL assert in STREAM only when reads remain and (FIFO occupancy + reads in flight) < 2, counted against the current-cycle pop.
REQ-024 o_rd_addr SHALL start at 0 per frame and increment by 1 per o_rd_en, never exceeding IX*IY-1; exactly IX*IY reads per frame.
REQ-025 While o_valid && !i_ready, o_pixel, o_row, o_col, o_sof, o_eol, o_eof SHALL hold stable.
REQ-026 o_col SHALL wrap IX-1->0 with o_row incrementing; o_row SHALL reach IY-1 on the last pixel.
REQ-027 Latency: i_start sampled at edge N -> o_rd_en with addr 0 during cycle N+1 -> o_valid with pixel 0 during cycle N+2.
REQ-028 With i_ready held 1, throughput SHALL be 1 pixel/cycle: pixel k presented in cycle N+2+k, o_done in cycle N+2+IX*IY.
REQ-029 Simultaneous FIFO push and pop SHALL keep occupancy unchanged and preserve order.
REQ-030 No pixel SHALL be dropped or duplicated under any i_ready pattern.

Reset
REQ-031 On reset_n=0 at a rising edge: state IDLE, FIFO empty, in-flight cleared, address/row/col counters 0.
REQ-032 During and after reset: o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0, o_valid=0, o_pixel=0, o_row=0, o_col=0, flags 0.
REQ-033 Reset mid-frame SHALL abort the frame; RAM data returning the cycle after reset SHALL be discarded.

Verification
REQ-034 RAM preloaded pixel[k]=k mod 256, i_ready=1, i_start at edge N -> 784 pixels in cycles N+2..N+785 in order, o_done at N+786.
REQ-035 i_ready toggled 1,0,0,1 repeating -> all 784 pixels received in order, outputs stable while stalled, o_rd_en never pushes occupancy+in-flight above 2.
REQ-036 i_start re-pulsed at pixel 100 -> ignored; exactly 784 pixels and one o_done.
REQ-037 reset_n=0 for one cycle at pixel 300 -> o_valid=0 next cycle, no stale pixel; new i_start restarts at row 0, col 0, o_sof=1.
REQ-038 Flag check -> o_sof only on (0,0); o_eol on col 27 of every row (28 times); o_eof only on (27,27) with pixel 783 mod 256 = 15.
REQ-039 i_start the cycle after o_done -> second frame begins with o_rd_addr=0 and identical timing to REQ-034.
